meta_write_sink: RTL
====================

# meta_write_sink

Consumer end of the data-cache metadata-write request channel. Accepts prioritised `{idx, way_en, tag}` write requests over a valid/ready handshake and buffers them in a small FIFO. Drains them into the single-ported tag SRAM whenever the array read port leaves the cycle free. Also exposes a same-index hazard probe, so the miss/probe path can stall on pending metadata updates.

## Interface

**Parameters**
- `DEPTH`, 2: FIFO entries, power of two, at least 2.
- `IDX_W`, 6: set-index width.
- `WAYS`, 8: associativity; width of `way_en`.
- `TAG_W`, 20: tag width.

**Ports**
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock`, in, 1: sole clock, rising edge.
  - `reset`, in, 1: asynchronous, active-low reset. Asserts immediately; deasserts synchronously to `clock`.
- Request channel:
  - `io_req_valid`, in, 1: request present.
  - `io_req_ready`, out, 1: sink can accept.
  - `io_req_bits_idx`, in, IDX_W: target set.
  - `io_req_bits_way_en`, in, WAYS: one-hot or multi-hot way mask.
  - `io_req_bits_tag`, in, TAG_W: tag to write.
- Tag array port:
  - `io_array_read_busy`, in, 1: the read port owns the array this cycle.
  - `io_array_write_en`, out, 1: write strobe.
  - `io_array_idx`, out, IDX_W: write address.
  - `io_array_way_mask`, out, WAYS: per-way write mask.
  - `io_array_tag`, out, TAG_W: write data.
- Hazard probe and status:
  - `io_probe_idx`, in, IDX_W: index under test.
  - `io_probe_hit`, out, 1: some buffered entry targets `io_probe_idx`.
  - `io_pending`, out, log2(DEPTH)+1: current occupancy.
  - `io_write_done`, out, 1: registered pulse one cycle after each array write.

## Operation

**FIFO state**
- Circular FIFO: `head` pointer, `tail` pointer and `count` register. Pointers wrap modulo DEPTH.

**Enqueue**
- `io_req_ready = (count != DEPTH)`, decoded from registered state only.
- No combinational path from `io_req_valid` to `io_req_ready`.
- Fire = `io_req_valid & io_req_ready`.
- On fire with `way_en != 0`: write the entry at `tail`, then `tail++`.
- On fire with `way_en == 0`: accept and discard. No enqueue and no array write.

**Drain**
- Drain condition: `count != 0 & ~io_array_read_busy`.
- When it holds, assert `io_array_write_en` with the head entry's fields, and dequeue that same cycle (`head++`).
- Read always has priority over write.
- There is no array-side backpressure beyond `read_busy`.

**Count update**
- Enqueue and dequeue in the same cycle leave `count` unchanged.
- When full, `io_req_ready` is 0 even if a dequeue happens that cycle. There is no pass-through when full.
- When empty, there is no bypass: a request cannot be written to the array in the cycle it arrives.

**Hazard probe**
- `io_probe_hit` is the OR over all valid entries of `(entry.idx == io_probe_idx)`.
- The probe is combinational on `io_probe_idx` and registered FIFO state.
- An entry being dequeued this cycle still counts as a hit.
- A request being accepted this cycle does not count until the next cycle.

**Status**
- `io_pending` equals `count`.
- `io_write_done` is `io_array_write_en` delayed one cycle.

**Reset**
- All state clears: `count=0`, `head=tail=0`, `write_done=0`.
- Reset values of outputs:
  - `io_req_ready=1`
  - `io_array_write_en=0`
  - `io_probe_hit=0`
  - `io_pending=0`
  - `io_write_done=0`
- Reset asserted mid-operation discards every buffered entry. No array write follows.
- Array data outputs are don't-care while `write_en=0`. They are driven from the head entry.

## Timing

- Minimum latency is 1 cycle: accepted at edge N, written in cycle N+1 if `read_busy` is low.
- Sustained throughput is 1 request per cycle while `read_busy` stays low.
- Each cycle `read_busy` is high delays the head entry by one cycle. Order is strictly FIFO.
- `io_req_ready` deasserts on the cycle after the accept that fills the FIFO.
- `io_req_ready` reasserts on the cycle after the first dequeue.

## Structure

**Shared package `meta_pkg`**
- `meta_write_t` struct: `idx`, `way_en`, `tag`.
- Width constants `IDX_W`, `WAYS`, `TAG_W`.
- Shared with the upstream arbiter.

**Sub-module**
- One sub-module, `meta_fifo`: a generic DEPTH-entry FIFO of `meta_write_t`.
- It exposes an entry-valid vector and the entry contents for the probe comparators.
- The top module holds the drain logic, the probe and `write_done`.

## Test plan

1. **Reset:** hold `reset=0` for 3 cycles with random inputs → `ready=1`, `write_en=0`, `pending=0`, `probe_hit=0` throughout.
2. **Single write:** request `idx=5`, `way_en=8'h04`, `tag=20'hABCDE`, with `read_busy=0` → array write with the same fields exactly 1 cycle later; `write_done` the cycle after that; `pending` goes 1 then 0.
3. **Backpressure:** hold `read_busy=1` and offer 3 requests with DEPTH=2 → first two accepted, `ready=0` on the third. Drop `read_busy` → writes leave in order, and the third is accepted the cycle after the first dequeue.
4. **Zero mask:** request with `way_en=0` → accepted, `pending` stays 0, no `write_en`.
5. **Hazard probe:** buffer `idx=12` with `read_busy=1`, probe `idx=12` → `hit=1`; probe `idx=13` → `hit=0`; after drain, probe `idx=12` → `hit=0`.
6. **Reset mid-operation:** two entries buffered, assert `reset` → `pending=0` at once, and no array write after release.

Source files
------------

// File: rtl/meta_pkg.sv
// Shared types for the data-cache metadata-write channel.
// Also imported by the upstream arbiter that produces these requests.
package meta_pkg;

    localparam int IDX_W = 6;
    localparam int WAYS  = 8;
    localparam int TAG_W = 20;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [WAYS-1:0]  way_en;
        logic [TAG_W-1:0] tag;
    } meta_write_t;

endpackage

// File: rtl/meta_fifo.sv
// Circular FIFO of metadata-write entries.
// The storage and per-entry valid bits are exported so the owner can run hazard comparators.
module meta_fifo
    import meta_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  meta_write_t      push_data,
    input  logic             pop,
    output meta_write_t      head_data,
    output meta_write_t      entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    meta_write_t      mem_q [DEPTH];
    meta_write_t      mem_d [DEPTH];

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = tail_q + PTR_W'(1);
        end else begin
            tail_d        = tail_q;
        end

        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end else begin
            head_d = head_q;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset discards every buffered entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    // Slot i is live when its distance from head (mod DEPTH) is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - head_q)} < count_q);
        end
    end

    assign head_data = mem_q[head_q];
    assign entries   = mem_q;
    assign count     = count_q;

endmodule

// File: rtl/meta_write_sink.sv
// Sink for metadata-write requests: buffers them and drains into the tag SRAM
// on cycles the read port leaves free, with a same-index hazard probe.
module meta_write_sink
    import meta_pkg::meta_write_t;
#(
    parameter  int DEPTH = 2,
    parameter  int IDX_W = meta_pkg::IDX_W,
    parameter  int WAYS  = meta_pkg::WAYS,
    parameter  int TAG_W = meta_pkg::TAG_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_req_valid,
    output logic             io_req_ready,
    input  logic [IDX_W-1:0] io_req_bits_idx,
    input  logic [WAYS-1:0]  io_req_bits_way_en,
    input  logic [TAG_W-1:0] io_req_bits_tag,
    input  logic             io_array_read_busy,
    output logic             io_array_write_en,
    output logic [IDX_W-1:0] io_array_idx,
    output logic [WAYS-1:0]  io_array_way_mask,
    output logic [TAG_W-1:0] io_array_tag,
    input  logic [IDX_W-1:0] io_probe_idx,
    output logic             io_probe_hit,
    output logic [CNT_W-1:0] io_pending,
    output logic             io_write_done
);

    logic             fire_s;
    logic             push_s;
    logic             drain_s;
    logic             probe_hit_s;
    logic [CNT_W-1:0] count_s;
    logic [DEPTH-1:0] entry_valid_s;
    meta_write_t      req_s;
    meta_write_t      head_s;
    meta_write_t      entries_s [DEPTH];
    logic             write_done_q, write_done_d;

    // Ready comes only from registered occupancy, so a full FIFO never passes through.
    assign io_req_ready = (count_s != CNT_W'(DEPTH));
    assign fire_s       = io_req_valid & io_req_ready;
    assign push_s       = fire_s & (|io_req_bits_way_en);
    assign drain_s      = (count_s != CNT_W'(0)) & ~io_array_read_busy;

    // Pack the incoming request into the shared entry format.
    always_comb begin
        req_s.idx    = io_req_bits_idx;
        req_s.way_en = io_req_bits_way_en;
        req_s.tag    = io_req_bits_tag;
    end

    meta_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clock),
        .rst_n       (reset),
        .push        (push_s),
        .push_data   (req_s),
        .pop         (drain_s),
        .head_data   (head_s),
        .entries     (entries_s),
        .entry_valid (entry_valid_s),
        .count       (count_s)
    );

    assign io_array_write_en = drain_s;
    assign io_array_idx      = head_s.idx;
    assign io_array_way_mask = head_s.way_en;
    assign io_array_tag      = head_s.tag;
    assign io_pending        = count_s;

    // Hazard probe over registered entries; an entry leaving this cycle still matches.
    always_comb begin
        probe_hit_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            probe_hit_s = probe_hit_s | (entry_valid_s[i] & (entries_s[i].idx == io_probe_idx));
        end
    end
    assign io_probe_hit = probe_hit_s;

    // Completion pulse trails the array write strobe by one cycle.
    always_comb begin
        write_done_d = drain_s;
    end

    // Completion pulse register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            write_done_q <= 1'b0;
        end else begin
            write_done_q <= write_done_d;
        end
    end
    assign io_write_done = write_done_q;

endmodule
